output_port_arbiter: RTL and testbench
======================================

# output_port_arbiter

Per-output-port scheduler for the router. It shares one output link between the four input ports, whose demultiplexers each present a 14-bit modified flit (6-bit modified header + 8-bit message) aimed at this port. Requesters are served in round-robin order, one flit per grant. Accepted flits are buffered in a small FIFO and released downstream under `portBlock` backpressure. A drain/halt handshake lets configuration logic, for example when changing `routerAddress`, quiesce the port safely.

## Interface
Parameters:
- `modifiedFlitSize`, 14, flit width after header modification.
- `numPorts`, 4, number of requesting input ports; the design is fixed at 4.
- `fifoDepth`, 2, output buffer depth; must be ≥1.

Ports:
- `clk`  input  1  single clock; all state updates on its rising edge.
- `resetN`  input  1  reset, asynchronous assert, active-low.
- `reqValid`  input  4  bit i set = input port i+1 presents a flit for this output.
- `flitIn1`..`flitIn4`  input  14 each  flits from input ports 1..4; must be stable while the matching `reqValid` bit is high.
- `reqReady`  output  4  one-hot, combinational; bit i high = flit i is accepted at this clock edge.
- `outFlit`  output  14  head-of-FIFO flit.
- `outValid`  output  1  FIFO non-empty.
- `portBlock`  input  1  downstream cannot accept; when high, nothing is popped.
- `drainReq`  input  1  level request to stop granting and empty the FIFO.
- `drainDone`  output  1  high while halted with the FIFO empty.

## Operation
- FSM states and transitions:
  - `RUN`, the reset state. Moves to `DRAIN` on `drainReq`=1.
  - `DRAIN`. Moves to `HALTED` when `count`==0. Returns to `RUN` if `drainReq` drops first.
  - `HALTED`. Returns to `RUN` when `drainReq`=0.
- Grant rule:
  - Grants happen only in `RUN` with `count` < `fifoDepth` and at least one `reqValid` bit set.
  - The winner is the first set `reqValid` bit scanning `rrPtr`, `rrPtr`+1, … modulo 4.
  - `reqReady` is the one-hot winner and is all-zero otherwise.
  - No grant is ever issued in `DRAIN` or `HALTED`.
- Pointer update: on a grant to index i, `rrPtr` <= (i+1) mod 4 (2-bit wrap). With no grant, `rrPtr` holds.
- Push: the winning flit is written at the FIFO tail.
- Pop: occurs when `outValid` && !`portBlock`; the head advances.
- Count rules:
  - `count` is clog2(`fifoDepth`+1) bits wide.
  - Push and pop in the same cycle leave `count` unchanged.
  - When full, no push occurs even if a pop happens that cycle; there is no full-bypass.
- `outValid` = (`count` != 0). `outFlit` is the head entry and holds its value while `portBlock`=1.
- `drainDone` = (state == `HALTED`).

## Timing
- Reset values (`resetN` low, asynchronous): state `RUN`, `rrPtr`=0, `count`=0, storage and pointers 0, `outValid`=0, `outFlit`=0, `drainDone`=0, `reqReady`=0.
- Reset asserted mid-operation discards all buffered flits immediately.
- Latency: a flit accepted at edge N is visible on `outFlit`/`outValid` after edge N; throughput is 1 flit/cycle with `portBlock`=0.
- A requester holds `reqValid` and its flit until it sees `reqReady` high at an edge. Dropping `reqValid` without a grant is legal and discards nothing.
- `drainReq` rising while a grant is combinationally active: that cycle's grant completes, and state is `DRAIN` from the next cycle.
- `drainReq` set with an empty FIFO: `RUN`→`DRAIN`→`HALTED`, so `drainDone` is high 2 edges later.

## Structure
- Shared package `router_pkg` holds:
  - `flitWidth`=12, `modifiedFlitSize`=14, `modifiedHeaderWidth`=6, `messageSize`=8.
  - The 2-bit port index type.
  - The arbiter state enum (`RUN`, `DRAIN`, `HALTED`).
- Sub-module `flit_fifo`: a synchronous FIFO with parameters width and depth, and push/pop/count/head ports. It is reused by later input buffering.
- The round-robin select logic and the FSM stay in this module.

## Test plan
- Single requester: `reqValid`=4'b0100, `flitIn3`=14'h2A5, `portBlock`=0. Expect `reqReady`=4'b0100 at edge 1, `outFlit`=14'h2A5 with `outValid`=1 after edge 1, and `rrPtr`=3.
- All four requesting continuously, `portBlock`=0. Expect grants in order 1,2,3,4,1,… one per cycle, with no requester granted twice before all others are served.
- `portBlock`=1 with all requesting, `fifoDepth`=2. Expect exactly 2 grants, then `reqReady`=0. `outFlit` holds the first flit. After `portBlock` is released, flits leave in acceptance order.
- Pointer wrap: `rrPtr`=3 and `reqValid`=4'b1001. Expect port 4 granted, then port 1 on the next cycle.
- Drain with 2 buffered flits and `portBlock`=0. Expect no grants, 2 pops, then `drainDone`=1. Dropping `drainReq` resumes grants on the next cycle.
- `resetN` pulsed low mid-stream with a full FIFO. Expect `outValid`=0 and `count`=0 immediately, and the first grant after release to go to port 1.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router types and widths: flit geometry, port index and arbiter state.
package router_pkg;

    localparam int unsigned flitWidth           = 12;
    localparam int unsigned modifiedFlitSize    = 14;
    localparam int unsigned modifiedHeaderWidth = 6;
    localparam int unsigned messageSize         = 8;

    typedef logic [1:0] port_idx_t;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } arb_state_t;

endpackage

// File: rtl/flit_fifo.sv
// Synchronous circular FIFO; caller must not push when full or pop when empty.
module flit_fifo #(
    parameter int unsigned width = 14,
    parameter int unsigned depth = 2,
    localparam int unsigned countWidth = $clog2(depth + 1)
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  push,
    input  logic                  pop,
    input  logic [width-1:0]      din,
    output logic [width-1:0]      head,
    output logic [countWidth-1:0] count
);

    localparam int unsigned ptrWidth = (depth > 1) ? $clog2(depth) : 1;
    localparam logic [ptrWidth-1:0] lastPtr = ptrWidth'(depth - 1);

    logic [width-1:0]    mem [depth];
    logic [ptrWidth-1:0] wrPtr;
    logic [ptrWidth-1:0] rdPtr;

    function automatic logic [ptrWidth-1:0] nextPtr(input logic [ptrWidth-1:0] p);
        return (p == lastPtr) ? '0 : p + ptrWidth'(1);
    endfunction

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < int'(depth); i++) begin
                mem[i] <= '0;
            end
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wrPtr] <= din;
                wrPtr      <= nextPtr(wrPtr);
            end
            if (pop) begin
                rdPtr <= nextPtr(rdPtr);
            end
            case ({push, pop})
                2'b10:   count <= count + countWidth'(1);
                2'b01:   count <= count - countWidth'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rdPtr];

endmodule

// File: rtl/output_port_arbiter.sv
// Round-robin arbiter for one output link: grants one of four input ports per cycle into a
// small FIFO and supports a drain/halt handshake for safe reconfiguration.
module output_port_arbiter #(
    parameter int unsigned modifiedFlitSize = 14,
    parameter int unsigned numPorts         = 4,
    parameter int unsigned fifoDepth        = 2
) (
    input  logic                        clk,
    input  logic                        resetN,
    input  logic [numPorts-1:0]         reqValid,
    input  logic [modifiedFlitSize-1:0] flitIn1,
    input  logic [modifiedFlitSize-1:0] flitIn2,
    input  logic [modifiedFlitSize-1:0] flitIn3,
    input  logic [modifiedFlitSize-1:0] flitIn4,
    output logic [numPorts-1:0]         reqReady,
    output logic [modifiedFlitSize-1:0] outFlit,
    output logic                        outValid,
    input  logic                        portBlock,
    input  logic                        drainReq,
    output logic                        drainDone
);

    import router_pkg::*;

    localparam int unsigned countWidth = $clog2(fifoDepth + 1);
    localparam logic [countWidth-1:0] fullCount = countWidth'(fifoDepth);

    arb_state_t                  state;
    port_idx_t                   rrPtr;
    port_idx_t                   winIdx;
    port_idx_t                   scanIdx;
    logic                        found;
    logic                        grant;
    logic                        pop;
    logic [countWidth-1:0]       count;
    logic [modifiedFlitSize-1:0] winFlit;

    // First requester at or after rrPtr, wrapping over the four ports.
    always_comb begin
        found   = 1'b0;
        winIdx  = rrPtr;
        scanIdx = rrPtr;
        for (int k = 0; k < 4; k++) begin
            scanIdx = rrPtr + port_idx_t'(k);
            if (!found && reqValid[scanIdx]) begin
                found  = 1'b1;
                winIdx = scanIdx;
            end
        end
    end

    always_comb begin
        case (winIdx)
            2'd0:    winFlit = flitIn1;
            2'd1:    winFlit = flitIn2;
            2'd2:    winFlit = flitIn3;
            default: winFlit = flitIn4;
        endcase
    end

    // Gated by resetN so no grant is advertised while reset is held.
    assign grant    = resetN && (state == RUN) && (count < fullCount) && found;
    assign reqReady = grant ? (numPorts'(1) << winIdx) : '0;
    assign outValid = (count != '0);
    assign pop      = outValid && !portBlock;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= RUN;
            rrPtr <= '0;
        end else begin
            if (grant) begin
                rrPtr <= winIdx + port_idx_t'(1);
            end
            case (state)
                RUN: begin
                    if (drainReq) state <= DRAIN;
                end
                DRAIN: begin
                    if (!drainReq)          state <= RUN;
                    else if (count == '0)   state <= HALTED;
                end
                HALTED: begin
                    if (!drainReq) state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    assign drainDone = (state == HALTED);

    flit_fifo #(
        .width (modifiedFlitSize),
        .depth (fifoDepth)
    ) u_fifo (
        .clk    (clk),
        .resetN (resetN),
        .push   (grant),
        .pop    (pop),
        .din    (winFlit),
        .head   (outFlit),
        .count  (count)
    );

endmodule

// File: tb/tb_output_port_arbiter.sv
// Bench for output_port_arbiter: queue-based reference model checked every cycle plus
// directed scenarios with literal expectations.
module tb_output_port_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        resetN;
    logic [3:0]  reqValid;
    logic [13:0] fin [4];
    logic [3:0]  reqReady;
    logic [13:0] outFlit;
    logic        outValid;
    logic        portBlock;
    logic        drainReq;
    logic        drainDone;

    int checks = 0;
    int errors = 0;

    output_port_arbiter #(
        .modifiedFlitSize (14),
        .numPorts         (4),
        .fifoDepth        (DEPTH)
    ) dut (
        .clk       (clk),
        .resetN    (resetN),
        .reqValid  (reqValid),
        .flitIn1   (fin[0]),
        .flitIn2   (fin[1]),
        .flitIn3   (fin[2]),
        .flitIn4   (fin[3]),
        .reqReady  (reqReady),
        .outFlit   (outFlit),
        .outValid  (outValid),
        .portBlock (portBlock),
        .drainReq  (drainReq),
        .drainDone (drainDone)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: flit queue, pointer and mode (0 run, 1 drain, 2 halted).
    logic [13:0] mq [$];
    int          mptr;
    int          mstate;
    bit          g_any;
    int          g_win;
    logic [13:0] g_flit;

    always @(negedge clk) begin
        logic [3:0] e_ready;
        bit         e_valid;
        bit         any;
        int         w;
        any = 0;
        w   = 0;
        if (!resetN) begin
            e_ready = 4'b0;
            e_valid = 0;
        end else begin
            e_valid = (mq.size() > 0);
            if (mstate == 0 && mq.size() < DEPTH) begin
                for (int k = 0; k < 4; k++) begin
                    int j;
                    j = (mptr + k) % 4;
                    if (!any && reqValid[j]) begin
                        any = 1;
                        w   = j;
                    end
                end
            end
            e_ready = any ? (4'b0001 << w) : 4'b0000;
        end
        g_any  = any;
        g_win  = w;
        g_flit = fin[w];
        chk("model_reqReady", {28'b0, reqReady}, {28'b0, e_ready});
        chk("model_outValid", {31'b0, outValid}, {31'b0, e_valid});
        chk("model_drainDone", {31'b0, drainDone}, {31'b0, (resetN && mstate == 2)});
        if (e_valid) chk("model_outFlit", {18'b0, outFlit}, {18'b0, mq[0]});
    end

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            mq.delete();
            mptr   = 0;
            mstate = 0;
        end else begin
            case (mstate)
                0: if (drainReq) mstate = 1;
                1: if (!drainReq) mstate = 0; else if (mq.size() == 0) mstate = 2;
                default: if (!drainReq) mstate = 0;
            endcase
            if (mq.size() > 0 && !portBlock) void'(mq.pop_front());
            if (g_any) begin
                mq.push_back(g_flit);
                mptr = (g_win + 1) % 4;
            end
        end
    end

    int glog [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run n cycles; on a grant either refresh that port's flit or drop its request.
    task automatic run(input int n, input bit refresh, output int ngr);
        logic [3:0] g;
        ngr = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            g = reqReady;
            for (int j = 0; j < 4; j++) begin
                if (g[j]) begin
                    ngr++;
                    glog.push_back(j);
                end
            end
            tick();
            for (int j = 0; j < 4; j++) begin
                if (g[j]) begin
                    if (refresh) fin[j] = fin[j] + 14'h11;
                    else         reqValid[j] = 1'b0;
                end
            end
        end
    endtask

    initial begin
        int n;
        int expOrder [8];
        expOrder = '{0, 1, 2, 3, 0, 1, 2, 3};
        resetN    = 1'b0;
        portBlock = 1'b0;
        drainReq  = 1'b0;
        reqValid  = 4'hF;
        for (int j = 0; j < 4; j++) fin[j] = 14'(16'h0100 * (j + 1));
        #2;
        chk("reset_reqReady", {28'b0, reqReady}, 32'h0);
        chk("reset_outValid", {31'b0, outValid}, 32'h0);
        chk("reset_outFlit", {18'b0, outFlit}, 32'h0);
        chk("reset_drainDone", {31'b0, drainDone}, 32'h0);
        tick();
        resetN = 1'b1;

        // All four requesting continuously.
        glog.delete();
        run(8, 1'b1, n);
        chk("rr_grant_count", n, 8);
        for (int i = 0; i < 8; i++) begin
            chk("rr_order", (i < glog.size()) ? glog[i] : -1, expOrder[i]);
        end
        reqValid = 4'h0;
        repeat (3) tick();

        // Single requester on port 3.
        fin[2]   = 14'h2A5;
        reqValid = 4'b0100;
        @(negedge clk);
        chk("single_reqReady", {28'b0, reqReady}, 32'h4);
        tick();
        reqValid = 4'b0000;
        chk("single_outFlit", {18'b0, outFlit}, 32'h2A5);
        chk("single_outValid", {31'b0, outValid}, 32'h1);

        // Pointer wrap from 3 with ports 1 and 4 requesting.
        fin[3]   = 14'h3C3;
        fin[0]   = 14'h111;
        reqValid = 4'b1001;
        @(negedge clk);
        chk("wrap_first", {28'b0, reqReady}, 32'h8);
        tick();
        reqValid = 4'b0001;
        @(negedge clk);
        chk("wrap_second", {28'b0, reqReady}, 32'h1);
        tick();
        reqValid = 4'b0000;
        chk("wrap_outFlit", {18'b0, outFlit}, 32'h111);
        repeat (3) tick();

        // Backpressure: exactly fifoDepth grants, then order preserved on release.
        portBlock = 1'b1;
        for (int j = 0; j < 4; j++) fin[j] = 14'(16'h0A01 + j);
        reqValid = 4'hF;
        run(5, 1'b0, n);
        chk("block_grants", n, 2);
        chk("block_reqReady", {28'b0, reqReady}, 32'h0);
        chk("block_head", {18'b0, outFlit}, 32'h0A02);
        reqValid  = 4'h0;
        portBlock = 1'b0;
        tick();
        chk("release_second", {18'b0, outFlit}, 32'h0A03);
        tick();
        chk("release_empty", {31'b0, outValid}, 32'h0);

        // Drain with two buffered flits.
        portBlock = 1'b1;
        fin[0]    = 14'h0B01;
        fin[1]    = 14'h0B02;
        reqValid  = 4'b0011;
        run(3, 1'b0, n);
        chk("drain_fill", n, 2);
        for (int j = 0; j < 4; j++) fin[j] = 14'(16'h0C01 + j);
        reqValid  = 4'hF;
        drainReq  = 1'b1;
        portBlock = 1'b0;
        run(4, 1'b0, n);
        chk("drain_nogrant", n, 0);
        chk("drain_done", {31'b0, drainDone}, 32'h1);
        chk("drain_empty", {31'b0, outValid}, 32'h0);
        drainReq = 1'b0;
        @(negedge clk);
        chk("halt_nogrant", {28'b0, reqReady}, 32'h0);
        tick();
        chk("resume_done_low", {31'b0, drainDone}, 32'h0);
        @(negedge clk);
        chk("resume_grant", {28'b0, reqReady}, 32'h4);
        tick();
        reqValid = 4'h0;
        repeat (4) tick();

        // Reset mid-stream with a full FIFO.
        portBlock = 1'b1;
        for (int j = 0; j < 4; j++) fin[j] = 14'(16'h0D01 + j);
        reqValid = 4'hF;
        run(3, 1'b0, n);
        chk("prereset_grants", n, 2);
        #2;
        resetN = 1'b0;
        #1;
        chk("midreset_outValid", {31'b0, outValid}, 32'h0);
        chk("midreset_reqReady", {28'b0, reqReady}, 32'h0);
        chk("midreset_outFlit", {18'b0, outFlit}, 32'h0);
        reqValid  = 4'hF;
        portBlock = 1'b0;
        tick();
        resetN = 1'b1;
        @(negedge clk);
        chk("postreset_grant", {28'b0, reqReady}, 32'h1);
        repeat (3) tick();
        reqValid = 4'h0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
